// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared FSM encoding and default constants for the FIFO-fed UART transmitter
package fifo_uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// rtl/fifo_uart_tx_baud_gen.sv - wrapping bit-period counter with synchronous clear and end-of-bit tick
module fifo_uart_tx_baud_gen
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             bit_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk) begin
        if (clr || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops FIFO words and serialises each as a UART frame (start, data LSB first, stop)
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  txEn,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] inData,
    output logic                  rdEn,
    output logic                  tx,
    output logic                  busy,
    output logic                  frameDone
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int                BIT_W     = $clog2(DATA_WIDTH) + 1;
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BAUD_W-1:0] PRE_TICK  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shift;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  stop_cnt;
    logic                  baud_clr;
    logic [BAUD_W-1:0]     baud_cnt;
    logic                  bit_tick;

    // Holding the counter clear until START makes every bit period begin at count 0.
    assign baud_clr = rst || (state == IDLE) || (state == FETCH) || (state == LOAD);

    fifo_uart_tx_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (BAUD_W)
    ) u_baud_gen (
        .clk      (clk),
        .clr      (baud_clr),
        .count    (baud_cnt),
        .bit_tick (bit_tick)
    );

    // Outputs are registered, so each is loaded with the value for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            rdEn      <= 1'b0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
            shift     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
        end else begin
            rdEn      <= 1'b0;
            frameDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (txEn && !empty) begin
                        state <= FETCH;
                        rdEn  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    shift <= inData;
                    tx    <= 1'b0;
                    state <= START;
                end
                START: begin
                    if (bit_tick) begin
                        tx      <= shift[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            tx       <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                        end else begin
                            tx      <= shift[1];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Raised one cycle early so the registered pulse lands on the final stop cycle.
                    if (stop_cnt == LAST_STOP && baud_cnt == PRE_TICK) begin
                        frameDone <= 1'b1;
                    end
                    if (bit_tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench: behavioural FIFO, UART line decoder and per-scenario tasks
module tb_fifo_uart_tx;

    localparam int CLKS  = 4;
    localparam int DW    = 8;
    localparam int SB    = 1;
    localparam int DEPTH = 8;
    localparam int FB    = 1 + DW + SB;
    localparam int FRAME = FB * CLKS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          txEn = 1'b1;
    logic          empty = 1'b1;
    logic          full = 1'b0;
    logic [DW-1:0] inData = '0;
    logic          rdEn, tx, busy, frameDone;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CLKS),
        .STOP_BITS    (SB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .txEn      (txEn),
        .empty     (empty),
        .inData    (inData),
        .rdEn      (rdEn),
        .tx        (tx),
        .busy      (busy),
        .frameDone (frameDone)
    );

    // Behavioural FIFO: read data appears the cycle after rdEn, flags update on the clock edge.
    logic [DW-1:0] fifo_q[$];
    int underflows = 0;
    always @(posedge clk) begin
        if (rdEn) begin
            if (fifo_q.size() == 0) underflows++;
            else inData <= fifo_q.pop_front();
        end
        if (wr_en && fifo_q.size() < DEPTH) fifo_q.push_back(wr_data);
        empty <= (fifo_q.size() == 0);
        full  <= (fifo_q.size() == DEPTH);
    end

    // Line decoder: records every complete frame seen on tx with its timing properties.
    typedef struct {
        logic [DW-1:0] word;
        logic [FB-1:0] lvl;
        bit            bits_ok;
        bit            done_ok;
        int            gap;
        int            rd_lat;
    } frame_t;

    frame_t rx_q[$];
    frame_t cur;
    bit     rx_active = 1'b0;
    int     rx_pos = 0;
    int     cyc = 0;
    int     last_end = -1;
    int     rd_cyc = 0;
    int     rd_count = 0;
    int     fd_count = 0;
    logic   cur_lvl;

    always @(negedge clk) begin
        if (rdEn === 1'b1) begin
            rd_count++;
            rd_cyc = cyc;
        end
        if (frameDone === 1'b1) fd_count++;
        if (rst) begin
            rx_active = 1'b0;
            last_end  = -1;
        end else begin
            if (!rx_active && tx === 1'b0) begin
                rx_active   = 1'b1;
                rx_pos      = 0;
                cur.bits_ok = 1'b1;
                cur.done_ok = 1'b1;
                cur.lvl     = '0;
                cur.gap     = (last_end < 0) ? -1 : cyc - last_end - 1;
                cur.rd_lat  = cyc - rd_cyc;
            end
            if (rx_active) begin
                if (rx_pos % CLKS == 0) cur_lvl = tx;
                else if (tx !== cur_lvl) cur.bits_ok = 1'b0;
                if (rx_pos % CLKS == CLKS - 1) cur.lvl[rx_pos / CLKS] = cur_lvl;
                if (frameDone !== (rx_pos == FRAME - 1)) cur.done_ok = 1'b0;
                if (rx_pos == FRAME - 1) begin
                    cur.word = cur.lvl[DW:1];
                    if (cur.lvl[FB-1:DW+1] !== '1) cur.bits_ok = 1'b0;
                    rx_q.push_back(cur);
                    rx_active = 1'b0;
                    last_end  = cyc;
                end
                rx_pos++;
            end
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (empty === 1'b1 && busy === 1'b0 && !rx_active) begin
                ok = 1'b1;
                break;
            end
        end
        step(1);
    endtask

    task automatic test_reset();
        int lows;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
            checks++; if (rdEn !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b expected 0", rdEn); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        end
        rst  = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        step(1);
        checks++; if (rd_count !== 0) begin errors++; $display("FAIL idle_rden: got %0d pulses expected 0", rd_count); end
        checks++; if (lows !== 0) begin errors++; $display("FAIL idle_line: got %0d active cycles expected 0", lows); end
    endtask

    task automatic test_single();
        int            base = rx_q.size();
        int            rd0 = rd_count;
        int            fd0 = fd_count;
        bit            ok;
        logic [FB-1:0] exp_seq = 10'b11_0100_1010;
        push(8'hA5);
        wait_drain(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got busy/queue pending expected drained"); end
        checks++; if (rd_count - rd0 != 1) begin errors++; $display("FAIL single_rden: got %0d expected 1", rd_count - rd0); end
        checks++; if (fd_count - fd0 != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", fd_count - fd0); end
        checks++;
        if (rx_q.size() - base != 1) begin
            errors++; $display("FAIL single_frames: got %0d expected 1", rx_q.size() - base);
        end else begin
            checks++; if (rx_q[base].lvl !== exp_seq) begin errors++; $display("FAIL single_seq: got %b expected %b", rx_q[base].lvl, exp_seq); end
            checks++; if (!rx_q[base].bits_ok) begin errors++; $display("FAIL single_bits: got ragged bit periods expected %0d-cycle bits", CLKS); end
            checks++; if (!rx_q[base].done_ok) begin errors++; $display("FAIL single_done_pos: got misplaced frameDone expected cycle %0d", FRAME); end
            checks++; if (rx_q[base].rd_lat != 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", rx_q[base].rd_lat); end
        end
    endtask

    task automatic test_burst();
        int  base = rx_q.size();
        int  rd0 = rd_count;
        bit  ok = 1'b0;
        for (int i = 1; i <= 3; i++) push(8'(i));
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rd_count - rd0 >= 3) begin ok = 1'b1; break; end
        end
        step(1);
        checks++; if (!ok) begin errors++; $display("FAIL burst_third_read: got %0d reads expected 3", rd_count - rd0); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL burst_empty: got %b expected 1", empty); end
        wait_drain(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_timeout: got pending expected drained"); end
        checks++;
        if (rx_q.size() - base != 3) begin
            errors++; $display("FAIL burst_frames: got %0d expected 3", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (rx_q[base+i].word !== 8'(i + 1)) begin errors++; $display("FAIL burst_word%0d: got %h expected %h", i, rx_q[base+i].word, 8'(i + 1)); end
                if (i > 0) begin
                    checks++; if (rx_q[base+i].gap != 3) begin errors++; $display("FAIL burst_gap%0d: got %0d expected 3", i, rx_q[base+i].gap); end
                end
            end
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] words[DEPTH];
        int            base = rx_q.size();
        bit            ok = 1'b0;
        int            rd0 = rd_count;
        txEn = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = 8'($urandom_range(0, 255));
            push(words[i]);
        end
        step(1);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
        txEn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_count != rd0) begin ok = 1'b1; break; end
        end
        step(1);
        checks++; if (!ok || full !== 1'b0) begin errors++; $display("FAIL fill_full_release: got full=%b read=%b expected full=0 read=1", full, ok); end
        wait_drain(DEPTH * (FRAME + 5) + 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fill_timeout: got pending expected drained"); end
        checks++;
        if (rx_q.size() - base != DEPTH) begin
            errors++; $display("FAIL fill_frames: got %0d expected %0d", rx_q.size() - base, DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (rx_q[base+i].word !== words[i] || !rx_q[base+i].bits_ok || !rx_q[base+i].done_ok) begin
                    errors++; $display("FAIL fill_word%0d: got %h (bits_ok=%b done_ok=%b) expected %h", i, rx_q[base+i].word, rx_q[base+i].bits_ok, rx_q[base+i].done_ok, words[i]);
                end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w2 = 8'($urandom_range(0, 255));
        int            base = rx_q.size();
        int            rd0 = rd_count;
        bit            ok = 1'b0;
        txEn = 1'b0;
        push(8'h3C);
        push(w2);
        txEn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_active && rx_pos >= 5 * CLKS + 1) begin ok = 1'b1; break; end
        end
        step(1);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_bit4: got no frame expected bit 4 in flight"); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        step(1);
        wait_drain(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: got pending expected drained"); end
        checks++; if (rd_count - rd0 != 2) begin errors++; $display("FAIL rstmid_reads: got %0d expected 2", rd_count - rd0); end
        checks++;
        if (rx_q.size() - base != 1) begin
            errors++; $display("FAIL rstmid_frames: got %0d expected 1", rx_q.size() - base);
        end else if (rx_q[base].word !== w2) begin
            errors++; $display("FAIL rstmid_word: got %h expected %h", rx_q[base].word, w2);
        end
    endtask

    task automatic test_txen_drop();
        logic [DW-1:0] w0 = 8'($urandom_range(0, 255));
        logic [DW-1:0] w1 = 8'($urandom_range(0, 255));
        int            base = rx_q.size();
        int            rd0 = rd_count;
        int            fd0 = fd_count;
        bit            ok = 1'b0;
        txEn = 1'b0;
        push(w0);
        push(w1);
        txEn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx_active && rx_pos > CLKS) begin ok = 1'b1; break; end
        end
        step(1);
        txEn = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL drop_start: got no frame expected frame in flight"); end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fd_count != fd0) begin ok = 1'b1; break; end
        end
        step(60);
        checks++; if (!ok) begin errors++; $display("FAIL drop_done: got no frameDone expected one"); end
        checks++; if (rd_count - rd0 != 1) begin errors++; $display("FAIL drop_reads: got %0d expected 1", rd_count - rd0); end
        checks++; if (busy !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL drop_hold: got busy=%b empty=%b expected busy=0 empty=0", busy, empty); end
        txEn = 1'b1;
        wait_drain(200, ok);
        checks++; if (rd_count - rd0 != 2) begin errors++; $display("FAIL drop_resume_reads: got %0d expected 2", rd_count - rd0); end
        checks++;
        if (rx_q.size() - base != 2) begin
            errors++; $display("FAIL drop_frames: got %0d expected 2", rx_q.size() - base);
        end else if (rx_q[base].word !== w0 || rx_q[base+1].word !== w1) begin
            errors++; $display("FAIL drop_words: got %h %h expected %h %h", rx_q[base].word, rx_q[base+1].word, w0, w1);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_q[$];
        int            base = rx_q.size();
        int            n = $urandom_range(4, 6);
        bit            ok;
        txEn = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(8'($urandom_range(0, 255)));
            push(exp_q[i]);
        end
        wait_drain(n * (FRAME + 5) + 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got pending expected drained"); end
        checks++;
        if (rx_q.size() - base != n) begin
            errors++; $display("FAIL b2b_frames: got %0d expected %0d", rx_q.size() - base, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (rx_q[base+i].word !== exp_q[i] || !rx_q[base+i].bits_ok || (i > 0 && rx_q[base+i].gap != 3)) begin
                    errors++; $display("FAIL b2b_frame%0d: got %h gap=%0d bits_ok=%b expected %h gap=3", i, rx_q[base+i].word, rx_q[base+i].gap, rx_q[base+i].bits_ok, exp_q[i]);
                end
            end
        end
        checks++; if (underflows != 0) begin errors++; $display("FAIL no_underflow: got %0d reads of empty FIFO expected 0", underflows); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_fill();
        test_reset_mid();
        test_txen_drop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
